// File: rtl/adder_err_monitor.sv
// adder_err_monitor: accumulates error statistics for an approximate 128-bit adder
// against its exact golden result over a fixed-length run of NUM_SAMPLES samples.
// Reports the sample count, error count, maximum and summed absolute error.
// Optional build macro ERR_HAMMING_EN adds a saturating total of differing bits
// (hamming_sum). Without it, hamming_sum is tied to zero.
module adder_err_monitor #(
  parameter int WIDTH       = 129,
  parameter int CNT_W       = 32,
  parameter int NUM_SAMPLES = 1000000,
  parameter int SUM_W       = 161
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] approx,
  input  logic [WIDTH-1:0] exact,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [WIDTH-1:0] max_abs_err,
  output logic [SUM_W-1:0] sum_abs_err,
  output logic             sum_sat,
  output logic [39:0]      hamming_sum,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] NS     = CNT_W'(NUM_SAMPLES);
  localparam logic [CNT_W-1:0] NS_M1  = NS - CNT_W'(1);
  // vld_pipe[0]: operands captured; vld_pipe[STAGES]: diff registered, stats update next edge
  localparam int               STAGES = 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                 state, state_nxt;
  logic                   kill;
  logic                   accept;
  logic                   last_accept;
  logic [CNT_W-1:0]       acc_cnt;
  logic [STAGES:0]        vld_pipe;

  logic [WIDTH-1:0]       a_q, e_q;
  logic [WIDTH:0]         dsub;
  logic [WIDTH-1:0]       diff_d, diff_q;
  logic                   neq_q;
  logic [SUM_W:0]         sum_ext;

  // rst and clear have identical effect on every piece of state
  assign kill        = rst | clear;
  assign accept      = in_valid & in_ready;
  assign last_accept = accept && (acc_cnt == NS_M1);

  // State register
  always_ff @(posedge clk) begin
    if (kill) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state: run starts on first accept, drains after the final accept
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = last_accept ? DRAIN : RUN;
      RUN:     if (last_accept) state_nxt = DRAIN;
      DRAIN:   if (vld_pipe == '0) state_nxt = DONE;
      DONE:    state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: ready until the run quota is taken; clear always blocks intake
  always_comb begin
    in_ready = (state != DONE) && (acc_cnt < NS) && !clear;
    busy     = (state == RUN) || (state == DRAIN);
    done     = (state == DONE);
  end

  // Count of accepted samples; bounds intake to NUM_SAMPLES per run
  always_ff @(posedge clk) begin
    if (kill)        acc_cnt <= '0;
    else if (accept) acc_cnt <= acc_cnt + CNT_W'(1);
  end

  // Pipeline valid shift register; in-flight samples are dropped on kill
  always_ff @(posedge clk) begin
    if (kill) vld_pipe <= '0;
    else      vld_pipe <= {vld_pipe[STAGES-1:0], accept};
  end

  // Capture operands on accept so the wide subtract gets a full cycle
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q <= approx;
      e_q <= exact;
    end
  end

  // One extra bit keeps the sign of the subtract; magnitude always fits in WIDTH
  always_comb begin
    dsub   = {1'b0, a_q} - {1'b0, e_q};
    diff_d = dsub[WIDTH] ? WIDTH'(-dsub) : dsub[WIDTH-1:0];
  end

  // S1: register magnitude and mismatch flag
  always_ff @(posedge clk) begin
    if (vld_pipe[0]) begin
      diff_q <= diff_d;
      neq_q  <= (a_q != e_q);
    end
  end

  // Carry out of the widened add marks accumulator overflow
  assign sum_ext = {1'b0, sum_abs_err} + (SUM_W+1)'(diff_q);

  // S2: fold the registered sample into the run statistics
  always_ff @(posedge clk) begin
    if (kill) begin
      sample_cnt  <= '0;
      err_cnt     <= '0;
      max_abs_err <= '0;
      sum_abs_err <= '0;
      sum_sat     <= 1'b0;
    end else if (vld_pipe[STAGES]) begin
      sample_cnt <= sample_cnt + CNT_W'(1);
      if (neq_q) err_cnt <= err_cnt + CNT_W'(1);
      if (diff_q > max_abs_err) max_abs_err <= diff_q;
      if (sum_ext[SUM_W]) begin
        sum_abs_err <= '1;
        sum_sat     <= 1'b1;
      end else begin
        sum_abs_err <= sum_ext[SUM_W-1:0];
      end
    end
  end

`ifdef ERR_HAMMING_EN
  localparam int POP_W = $clog2(WIDTH + 1);

  logic [POP_W-1:0] pop_d, pop_q;
  logic [40:0]      ham_ext;

  // Population count of differing bits
  always_comb begin
    pop_d = '0;
    for (int i = 0; i < WIDTH; i++) pop_d = pop_d + POP_W'(a_q[i] ^ e_q[i]);
  end

  // S1: register bit-difference count alongside the magnitude
  always_ff @(posedge clk) begin
    if (vld_pipe[0]) pop_q <= pop_d;
  end

  assign ham_ext = {1'b0, hamming_sum} + 41'(pop_q);

  // S2: saturating bit-difference total
  always_ff @(posedge clk) begin
    if (kill)                  hamming_sum <= '0;
    else if (vld_pipe[STAGES]) hamming_sum <= ham_ext[40] ? '1 : ham_ext[39:0];
  end
`else
  assign hamming_sum = '0;
`endif

endmodule

// File: tb/tb_adder_err_monitor.sv
// tb_adder_err_monitor: randomized and directed checks of adder_err_monitor.
// u_dut runs a 64-sample quota with default widths against a queue-based model;
// u_sml runs a 3-sample quota with a 129-bit accumulator for run-end and saturation cases.
module tb_adder_err_monitor;

  localparam int W   = 129;
  localparam int NS0 = 64;
  localparam int NS1 = 3;
  localparam int SW0 = 161;
  localparam int SW1 = 129;

  localparam logic [W-1:0]   ONES  = '1;
  localparam logic [SW0-1:0] SMAX0 = '1;
  localparam logic [SW1-1:0] SMAX1 = '1;
  localparam logic [39:0]    HMAX  = '1;
`ifdef ERR_HAMMING_EN
  localparam logic [39:0]    HAM_DIR = 40'd6;
`else
  localparam logic [39:0]    HAM_DIR = 40'd0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b1;
  logic         clr0 = 1'b0, v0 = 1'b0, clr1 = 1'b0, v1 = 1'b0;
  logic [W-1:0] a0 = '0, e0 = '0, a1 = '0, e1 = '0;

  logic           r0, sat0, busy0, done0;
  logic [31:0]    sc0, ec0;
  logic [W-1:0]   mx0;
  logic [SW0-1:0] sm0;
  logic [39:0]    hm0;

  logic           r1, sat1, busy1, done1;
  logic [31:0]    sc1, ec1;
  logic [W-1:0]   mx1;
  logic [SW1-1:0] sm1;
  logic [39:0]    hm1;

  int n_vec = 0;
  int n_err = 0;

  adder_err_monitor #(.WIDTH(W), .CNT_W(32), .NUM_SAMPLES(NS0), .SUM_W(SW0)) u_dut (
    .clk(clk), .rst(rst), .clear(clr0), .in_valid(v0), .in_ready(r0),
    .approx(a0), .exact(e0), .sample_cnt(sc0), .err_cnt(ec0),
    .max_abs_err(mx0), .sum_abs_err(sm0), .sum_sat(sat0), .hamming_sum(hm0),
    .busy(busy0), .done(done0));

  adder_err_monitor #(.WIDTH(W), .CNT_W(32), .NUM_SAMPLES(NS1), .SUM_W(SW1)) u_sml (
    .clk(clk), .rst(rst), .clear(clr1), .in_valid(v1), .in_ready(r1),
    .approx(a1), .exact(e1), .sample_cnt(sc1), .err_cnt(ec1),
    .max_abs_err(mx1), .sum_abs_err(sm1), .sum_sat(sat1), .hamming_sum(hm1),
    .busy(busy1), .done(done1));

  // ---------------- reference model for u_dut ----------------
  // Accepted samples wait in a queue tagged with the edge at which they must
  // appear in the statistics (accept edge + 2).
  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] e;
    int           due;
  } smp_t;

  smp_t           mq[$];
  int             ecnt = 0, m_acc = 0, fin_edge = 0;
  logic [31:0]    m_cnt = '0, m_err = '0;
  logic [W-1:0]   m_max = '0;
  logic [SW0-1:0] m_sum = '0;
  logic           m_sat = 1'b0;
  logic [39:0]    m_ham = '0;

  always @(posedge clk) begin : model
    logic [W-1:0] d;
    ecnt++;
    if (rst || clr0) begin
      mq.delete();
      m_acc = 0; m_cnt = '0; m_err = '0; m_max = '0;
      m_sum = '0; m_sat = 1'b0; m_ham = '0;
    end else begin
      while (mq.size() > 0 && mq[0].due == ecnt) begin
        d = (mq[0].a > mq[0].e) ? mq[0].a - mq[0].e : mq[0].e - mq[0].a;
        m_cnt++;
        if (mq[0].a != mq[0].e) m_err++;
        if (d > m_max) m_max = d;
        if (SMAX0 - m_sum < SW0'(d)) begin m_sum = SMAX0; m_sat = 1'b1; end
        else m_sum = m_sum + SW0'(d);
`ifdef ERR_HAMMING_EN
        if (HMAX - m_ham < 40'($countones(mq[0].a ^ mq[0].e))) m_ham = HMAX;
        else m_ham = m_ham + 40'($countones(mq[0].a ^ mq[0].e));
`endif
        void'(mq.pop_front());
      end
      if (v0 && m_acc < NS0) begin
        mq.push_back('{a0, e0, ecnt + 2});
        m_acc++;
        if (m_acc == NS0) fin_edge = ecnt;
      end
    end
  end

  function automatic logic [W-1:0] rnd129();
    return {$urandom(), $urandom(), $urandom(), $urandom(), 1'($urandom())};
  endfunction

  task automatic pick(output logic [W-1:0] a, output logic [W-1:0] e);
    case ($urandom % 4)
      0: begin a = rnd129(); e = rnd129(); end
      1: begin a = rnd129(); e = a; end
      2: begin a = rnd129(); e = a + W'($urandom % 256); end
      default: begin a = ($urandom % 2) ? ONES : '0; e = ($urandom % 2) ? ONES : rnd129(); end
    endcase
  endtask

  task automatic drive0(input logic v, input logic [W-1:0] a, input logic [W-1:0] e);
    @(negedge clk); v0 = v; a0 = a; e0 = e;
  endtask

  task automatic drive1(input logic v, input logic [W-1:0] a, input logic [W-1:0] e);
    @(negedge clk); v1 = v; a1 = a; e1 = e;
  endtask

  task automatic do_clear0();
    @(negedge clk); clr0 = 1'b1; v0 = 1'b0;
    @(negedge clk); clr0 = 1'b0;
  endtask

  task automatic do_clear1();
    @(negedge clk); clr1 = 1'b1; v1 = 1'b0;
    @(negedge clk); clr1 = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; v0 = 1'b1; v1 = 1'b1; a0 = rnd129(); a1 = rnd129();
    repeat (3) @(negedge clk);
    n_vec++; if (sc0 !== '0 || ec0 !== '0 || mx0 !== '0 || sm0 !== '0)
      begin n_err++; $display("FAIL reset_stats0: got sc=%0d ec=%0d mx=%h sm=%h want all 0", sc0, ec0, mx0, sm0); end
    n_vec++; if (sat0 !== 1'b0 || hm0 !== '0 || busy0 !== 1'b0 || done0 !== 1'b0)
      begin n_err++; $display("FAIL reset_flags0: got sat=%b hm=%h busy=%b done=%b want 0", sat0, hm0, busy0, done0); end
    n_vec++; if (sc1 !== '0 || sm1 !== '0 || sat1 !== 1'b0 || done1 !== 1'b0)
      begin n_err++; $display("FAIL reset_sml: got sc=%0d sm=%h sat=%b done=%b want 0", sc1, sm1, sat1, done1); end
    rst = 1'b0; v0 = 1'b0; v1 = 1'b0;
    @(negedge clk);
    n_vec++; if (r0 !== 1'b1 || r1 !== 1'b1)
      begin n_err++; $display("FAIL reset_ready: got %b/%b want 1/1", r0, r1); end
  endtask

  task automatic test_equal();
    logic [W-1:0] x;
    x = '0; x[128] = 1'b1; x[0] = 1'b1;
    repeat (4) drive0(1'b1, x, x);
    drive0(1'b0, '0, '0);
    repeat (3) @(negedge clk);
    n_vec++; if (sc0 !== 32'd4 || ec0 !== 32'd0)
      begin n_err++; $display("FAIL equal_cnt: got sc=%0d ec=%0d want 4 0", sc0, ec0); end
    n_vec++; if (mx0 !== '0 || sm0 !== '0 || hm0 !== '0)
      begin n_err++; $display("FAIL equal_err: got mx=%h sm=%h hm=%h want 0", mx0, sm0, hm0); end
  endtask

  task automatic test_directed();
    do_clear0();
    drive0(1'b1, W'(5), W'(3));
    drive0(1'b1, W'(3), W'(5));
    drive0(1'b1, W'(0), W'(10));
    drive0(1'b1, W'(7), W'(7));
    drive0(1'b0, '0, '0);
    repeat (3) @(negedge clk);
    n_vec++; if (sc0 !== 32'd4 || ec0 !== 32'd3)
      begin n_err++; $display("FAIL directed_cnt: got sc=%0d ec=%0d want 4 3", sc0, ec0); end
    n_vec++; if (mx0 !== W'(10) || sm0 !== SW0'(14))
      begin n_err++; $display("FAIL directed_err: got mx=%0d sm=%0d want 10 14", mx0, sm0); end
    n_vec++; if (hm0 !== HAM_DIR)
      begin n_err++; $display("FAIL directed_ham: got %0d want %0d", hm0, HAM_DIR); end
  endtask

  task automatic test_toggle();
    do_clear0();
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      n_vec++; if (sc0 !== m_cnt || ec0 !== m_err || sm0 !== m_sum)
        begin n_err++; $display("FAIL toggle_lat cyc%0d: got sc=%0d ec=%0d sm=%0d want %0d %0d %0d", k, sc0, ec0, sm0, m_cnt, m_err, m_sum); end
      v0 = (k % 2 == 0) && (k < 12); a0 = W'(1); e0 = '0;
    end
    v0 = 1'b0;
    n_vec++; if (sc0 !== 32'd6 || ec0 !== 32'd6 || sm0 !== SW0'(6))
      begin n_err++; $display("FAIL toggle_final: got sc=%0d ec=%0d sm=%0d want 6 6 6", sc0, ec0, sm0); end
  endtask

  task automatic test_clear_midrun();
    logic [W-1:0] ta, te;
    do_clear0();
    for (int k = 0; k < 5; k++) begin pick(ta, te); drive0(1'b1, ta, te); end
    @(negedge clk); clr0 = 1'b1; v0 = 1'b1; a0 = W'(9); e0 = W'(1);
    #1;
    n_vec++; if (r0 !== 1'b0)
      begin n_err++; $display("FAIL clear_ready: got %b want 0", r0); end
    @(negedge clk);
    n_vec++; if (sc0 !== '0 || ec0 !== '0 || mx0 !== '0 || sm0 !== '0 || busy0 !== 1'b0)
      begin n_err++; $display("FAIL clear_zero: got sc=%0d ec=%0d mx=%h sm=%h busy=%b want 0", sc0, ec0, mx0, sm0, busy0); end
    clr0 = 1'b0; v0 = 1'b1; a0 = W'(4); e0 = W'(9);
    drive0(1'b1, W'(2), W'(2));
    drive0(1'b0, '0, '0);
    repeat (3) @(negedge clk);
    n_vec++; if (sc0 !== 32'd2 || ec0 !== 32'd1 || sm0 !== SW0'(5) || mx0 !== W'(5))
      begin n_err++; $display("FAIL clear_after: got sc=%0d ec=%0d sm=%0d mx=%0d want 2 1 5 5", sc0, ec0, sm0, mx0); end
    n_vec++; if (sc0 !== m_cnt || sm0 !== m_sum)
      begin n_err++; $display("FAIL clear_model: got sc=%0d sm=%0d want %0d %0d", sc0, sm0, m_cnt, m_sum); end
  endtask

  // Full run to completion, random or continuous valid, compared every cycle
  task automatic test_run(input bit b2b);
    logic [W-1:0] ta, te;
    logic         exp_done;
    int           guard;
    guard = 0;
    do_clear0();
    while (!(m_acc == NS0 && ecnt - fin_edge >= 6) && guard < 600) begin
      @(negedge clk); guard++;
      exp_done = (m_acc == NS0) && (ecnt - fin_edge >= 3);
      n_vec++; if (r0 !== ((m_acc < NS0) && !clr0))
        begin n_err++; $display("FAIL run%0d_ready cyc%0d: got %b want %b", b2b, guard, r0, (m_acc < NS0)); end
      n_vec++; if (sc0 !== m_cnt || ec0 !== m_err)
        begin n_err++; $display("FAIL run%0d_cnt cyc%0d: got sc=%0d ec=%0d want %0d %0d", b2b, guard, sc0, ec0, m_cnt, m_err); end
      n_vec++; if (mx0 !== m_max || sm0 !== m_sum || sat0 !== m_sat)
        begin n_err++; $display("FAIL run%0d_err cyc%0d: got mx=%h sm=%h sat=%b want %h %h %b", b2b, guard, mx0, sm0, sat0, m_max, m_sum, m_sat); end
      n_vec++; if (hm0 !== m_ham || done0 !== exp_done)
        begin n_err++; $display("FAIL run%0d_hd cyc%0d: got hm=%0d done=%b want %0d %b", b2b, guard, hm0, done0, m_ham, exp_done); end
      if (m_acc < NS0 || exp_done) begin
        n_vec++; if (busy0 !== ((m_acc > 0) && !exp_done))
          begin n_err++; $display("FAIL run%0d_busy cyc%0d: got %b want %b", b2b, guard, busy0, (m_acc > 0) && !exp_done); end
      end
      pick(ta, te);
      v0 = b2b ? 1'b1 : 1'($urandom % 2); a0 = ta; e0 = te;
    end
    v0 = 1'b0;
    n_vec++; if (guard >= 600)
      begin n_err++; $display("FAIL run%0d_timeout: got %0d accepts want %0d", b2b, m_acc, NS0); end
    @(negedge clk);
    n_vec++; if (sc0 !== 32'(NS0) || done0 !== 1'b1 || r0 !== 1'b0)
      begin n_err++; $display("FAIL run%0d_end: got sc=%0d done=%b rdy=%b want %0d 1 0", b2b, sc0, done0, r0, NS0); end
  endtask

  task automatic test_saturate();
    do_clear1();
    drive1(1'b1, ONES, '0);
    drive1(1'b0, '0, '0);
    repeat (2) @(negedge clk);
    n_vec++; if (mx1 !== ONES || sm1 !== SMAX1 || sat1 !== 1'b0)
      begin n_err++; $display("FAIL sat_first: got mx=%h sm=%h sat=%b want all-ones all-ones 0", mx1, sm1, sat1); end
    drive1(1'b1, ONES, '0);
    drive1(1'b0, '0, '0);
    repeat (3) @(negedge clk);
    n_vec++; if (mx1 !== ONES || sm1 !== SMAX1 || sat1 !== 1'b1 || sc1 !== 32'd2)
      begin n_err++; $display("FAIL sat_second: got mx=%h sm=%h sat=%b sc=%0d want all-ones all-ones 1 2", mx1, sm1, sat1, sc1); end
  endtask

  task automatic test_num_samples();
    int exp_sc;
    do_clear1();
    v1 = 1'b1; a1 = W'(1); e1 = '0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      exp_sc = (k < 3) ? 0 : ((k - 2 > NS1) ? NS1 : k - 2);
      n_vec++; if (r1 !== (k < 3))
        begin n_err++; $display("FAIL ns_ready edge%0d: got %b want %b", k, r1, (k < 3)); end
      n_vec++; if (done1 !== (k >= 6))
        begin n_err++; $display("FAIL ns_done edge%0d: got %b want %b", k, done1, (k >= 6)); end
      n_vec++; if (sc1 !== 32'(exp_sc))
        begin n_err++; $display("FAIL ns_cnt edge%0d: got %0d want %0d", k, sc1, exp_sc); end
      if (k < 3 || k >= 6) begin
        n_vec++; if (busy1 !== (k < 3))
          begin n_err++; $display("FAIL ns_busy edge%0d: got %b want %b", k, busy1, (k < 3)); end
      end
    end
    v1 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_equal();
    test_directed();
    test_toggle();
    test_clear_midrun();
    test_run(1'b0);
    test_run(1'b1);
    test_saturate();
    test_num_samples();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got still running want finished");
    $fatal(1);
  end

endmodule
